// File: rtl/mycpu_if_stage.sv
// ============================================================================
// Module      : mycpu_if_stage
// Description : MIPS instruction-fetch stage with redirect and stall handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mycpu_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    input  logic [1:0]  id_c1,
    input  logic [31:0] id_jmp_addr,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_adel,
    output logic [31:0] perf_fetch_cnt
);

    localparam logic [0:0] S_BOOT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] C_NONE   = 2'b00;
    localparam logic [1:0] C_BRANCH = 2'b01;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic [31:0] r_perf_cnt;
    logic        w_advance;
    logic [31:0] w_next_pc;

    assign w_advance = (r_state == S_RUN) && id_allowin;

    // The branch sits at out_pc; its delay slot is already being fetched.
    always_comb begin
        w_next_pc = r_fetch_pc + 32'd4;
        if (id_c1 == C_BRANCH) begin
            w_next_pc = r_out_pc + 32'd4 + id_jmp_addr;
        end else if (id_c1 != C_NONE) begin
            w_next_pc = id_jmp_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
    end

    // A stall re-reads out_pc so the synchronous SRAM keeps returning it.
    always_comb begin
        inst_sram_en   = 1'b0;
        inst_sram_addr = r_fetch_pc;
        if_pc          = 32'd0;
        if_inst        = 32'd0;
        if_valid       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_BOOT: begin
                    inst_sram_en   = 1'b1;
                    inst_sram_addr = r_fetch_pc;
                    if_pc          = r_out_pc;
                end
                S_RUN: begin
                    inst_sram_en   = 1'b1;
                    inst_sram_addr = id_allowin ? r_fetch_pc : r_out_pc;
                    if_pc          = r_out_pc;
                    if_valid       = r_out_valid;
                    if_inst        = r_out_valid ? inst_sram_rdata : 32'd0;
                end
                default: begin
                    inst_sram_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_out_pc    <= 32'd0;
            r_out_valid <= 1'b0;
            r_perf_cnt  <= 32'd0;
        end else if (r_state == S_BOOT) begin
            r_out_pc    <= r_fetch_pc;
            r_out_valid <= 1'b1;
            r_fetch_pc  <= r_fetch_pc + 32'd4;
        end else if (w_advance) begin
            r_out_pc    <= r_fetch_pc;
            r_out_valid <= 1'b1;
            r_perf_cnt  <= r_perf_cnt + 32'd1;
            r_fetch_pc  <= w_next_pc;
        end
    end

    assign if_adel        = if_valid && (if_pc[1:0] != 2'b00);
    assign perf_fetch_cnt = r_perf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mycpu_if_stage.sv
// ============================================================================
// Module      : tb_mycpu_if_stage
// Description : Scenario and random checks of the fetch stage against a PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mycpu_if_stage;

    localparam logic [31:0] c_reset_pc = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_allowin = 1'b0;
    logic [1:0]  id_c1 = 2'b00;
    logic [31:0] id_jmp_addr = 32'd0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_adel;
    logic [31:0] perf_fetch_cnt;

    always #5 clk = ~clk;

    mycpu_if_stage #(.RESET_PC(c_reset_pc)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .id_c1          (id_c1),
        .id_jmp_addr    (id_jmp_addr),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .if_adel        (if_adel),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h3C5A96E1;
    endfunction

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
    end

    // Model: m_cur is the PC on show, m_nxt the PC that follows it in program order.
    logic        m_seen = 1'b0;
    logic        m_boot = 1'b1;
    logic [31:0] m_cur  = 32'd0;
    logic [31:0] m_nxt  = 32'd0;
    logic [31:0] m_cnt  = 32'd0;

    logic        d_rst, d_allow;
    logic [1:0]  d_c1;
    logic [31:0] d_jmp;

    logic [130:0] obs_vec, exp_vec, msk_vec;
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic string fmt(input logic [130:0] v);
        return $sformatf("en=%b addr=%h pc=%h inst=%h v=%b adel=%b cnt=%h",
                         v[130], v[129:98], v[97:66], v[65:34], v[33], v[32], v[31:0]);
    endfunction

    task automatic drive(input logic r, input logic a, input logic [1:0] c, input logic [31:0] j);
        logic        e_en, e_valid, e_adel, k_addr, k_pc;
        logic [31:0] e_addr, e_pc, e_inst;
        @(negedge clk);
        rst = r; id_allowin = a; id_c1 = c; id_jmp_addr = j;
        d_rst = r; d_allow = a; d_c1 = c; d_jmp = j;
        #1;
        e_en = 1'b0; e_valid = 1'b0; e_adel = 1'b0;
        e_addr = 32'd0; e_pc = 32'd0; e_inst = 32'd0;
        k_addr = 1'b1; k_pc = 1'b1;
        if (r) begin
            k_addr = 1'b0;
        end else if (m_boot) begin
            e_en = 1'b1; e_addr = c_reset_pc; k_pc = 1'b0;
        end else begin
            e_en    = 1'b1;
            e_addr  = a ? m_nxt : m_cur;
            e_pc    = m_cur;
            e_inst  = sram_word(m_cur);
            e_valid = 1'b1;
            e_adel  = (m_cur[1:0] != 2'b00);
        end
        exp_vec = {e_en, e_addr, e_pc, e_inst, e_valid, e_adel, m_cnt};
        msk_vec = {1'b1, {32{k_addr}}, {32{k_pc}}, {32{1'b1}}, 1'b1, 1'b1, {32{m_seen}}};
        obs_vec = {inst_sram_en, inst_sram_addr, if_pc, if_inst, if_valid, if_adel, perf_fetch_cnt};
    endtask

    task automatic step();
        logic [31:0] tgt;
        @(posedge clk);
        if (d_rst) begin
            m_seen = 1'b1; m_boot = 1'b1; m_cnt = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_cur = c_reset_pc; m_nxt = c_reset_pc + 32'd4;
        end else if (d_allow) begin
            case (d_c1)
                2'b00:   tgt = m_nxt + 32'd4;
                2'b01:   tgt = m_cur + 32'd4 + d_jmp;
                default: tgt = d_jmp;
            endcase
            m_cur = m_nxt; m_nxt = tgt; m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
                n_fail++; $display("FAIL reset[%0d]: got %s required %s", i, fmt(obs_vec), fmt(exp_vec & msk_vec));
            end
            step();
        end
    endtask

    task automatic test_boot();
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        n_cmp++;
        if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_valid !== 1'b0 || perf_fetch_cnt !== 32'd0) begin
            n_fail++; $display("FAIL boot_cycle: got %s required %s", fmt(obs_vec), fmt(exp_vec & msk_vec));
        end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== c_reset_pc + 32'(4 * i)
                || perf_fetch_cnt !== 32'(i)) begin
                n_fail++; $display("FAIL boot_seq[%0d]: got %s required pc=%h cnt=%0d", i, fmt(obs_vec),
                                   c_reset_pc + 32'(4 * i), i);
            end
            step();
        end
    endtask

    task automatic test_run_to(input logic [31:0] target);
        for (int k = 0; k < 64 && m_cur != target; k++) begin
            drive(1'b0, 1'b1, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
                n_fail++; $display("FAIL run_to: got %s required %s", fmt(obs_vec), fmt(exp_vec & msk_vec));
            end
            step();
        end
        if (m_cur != target) begin
            n_cmp++; n_fail++; $display("FAIL run_to_timeout: at %h required %h", m_cur, target);
        end
    endtask

    task automatic test_stall();
        test_run_to(32'hBFC00010);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== 32'hBFC00010
                || inst_sram_addr !== 32'hBFC00010 || if_inst !== sram_word(32'hBFC00010)
                || perf_fetch_cnt !== 32'd4) begin
                n_fail++; $display("FAIL stall[%0d]: got %s required pc=addr=bfc00010 cnt=4", i, fmt(obs_vec));
            end
            step();
        end
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        n_cmp++;
        if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== 32'hBFC00014) begin
            n_fail++; $display("FAIL stall_release: got %s required pc=bfc00014", fmt(obs_vec));
        end
        step();
    endtask

    task automatic test_branch();
        logic [31:0] seq [3];
        test_run_to(32'hBFC00020);
        seq[0] = 32'hBFC00020; seq[1] = 32'hBFC00024; seq[2] = 32'hBFC00014;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 2'b01 : 2'b00, (i == 0) ? 32'hFFFFFFF0 : 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== seq[i] || if_valid !== 1'b1) begin
                n_fail++; $display("FAIL branch[%0d]: got %s required pc=%h", i, fmt(obs_vec), seq[i]);
            end
            step();
        end
    endtask

    task automatic test_jumps();
        logic [31:0] seq [5];
        logic [1:0]  cls [5];
        logic [31:0] jmp [5];
        test_run_to(32'hBFC00030);
        seq[0] = 32'hBFC00030; cls[0] = 2'b10; jmp[0] = 32'hBFC00100;
        seq[1] = 32'hBFC00034; cls[1] = 2'b00; jmp[1] = 32'd0;
        seq[2] = 32'hBFC00100; cls[2] = 2'b11; jmp[2] = 32'hBFC00202;
        seq[3] = 32'hBFC00104; cls[3] = 2'b00; jmp[3] = 32'd0;
        seq[4] = 32'hBFC00202; cls[4] = 2'b00; jmp[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, cls[i], jmp[i]);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== seq[i]
                || if_adel !== (i == 4)) begin
                n_fail++; $display("FAIL jump[%0d]: got %s required pc=%h adel=%b", i, fmt(obs_vec), seq[i], i == 4);
            end
            step();
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] held;
        held = m_cur;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 2'b10, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== held) begin
                n_fail++; $display("FAIL stall_redirect_hold[%0d]: got %s required pc=%h", i, fmt(obs_vec), held);
            end
            step();
        end
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        n_cmp++;
        if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== held + 32'd4) begin
            n_fail++; $display("FAIL stall_redirect_resume: got %s required pc=%h", fmt(obs_vec), held + 32'd4);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] seq [3];
        drive(1'b0, 1'b1, 2'b10, 32'hFFFFFFF8);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        step();
        seq[0] = 32'hFFFFFFF8; seq[1] = 32'hFFFFFFFC; seq[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== seq[i] || if_inst !== sram_word(seq[i])) begin
                n_fail++; $display("FAIL wrap[%0d]: got %s required pc=%h", i, fmt(obs_vec), seq[i]);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic        a;
        logic [1:0]  c;
        logic [31:0] j;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            j = $urandom;
            if ($urandom_range(0, 7) != 0) j[1:0] = 2'b00;
            drive(1'b0, a, c, j);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec)) begin
                n_fail++; $display("FAIL random[%0d]: got %s required %s", i, fmt(obs_vec), fmt(exp_vec & msk_vec));
            end
            step();
        end
    endtask

    task automatic test_reset_midrun();
        drive(1'b0, 1'b0, 2'b00, 32'd0);
        step();
        drive(1'b1, 1'b0, 2'b10, 32'h12345678);
        n_cmp++;
        if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
            n_fail++; $display("FAIL midrun_rst: got %s required %s", fmt(obs_vec), fmt(exp_vec & msk_vec));
        end
        step();
        drive(1'b0, 1'b1, 2'b00, 32'd0);
        n_cmp++;
        if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_valid !== 1'b0 || perf_fetch_cnt !== 32'd0) begin
            n_fail++; $display("FAIL midrun_boot: got %s required valid=0 cnt=0", fmt(obs_vec));
        end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 2'b00, 32'd0);
            n_cmp++;
            if ((obs_vec & msk_vec) !== (exp_vec & msk_vec) || if_pc !== c_reset_pc + 32'(4 * i)) begin
                n_fail++; $display("FAIL midrun_restart[%0d]: got %s required pc=%h", i, fmt(obs_vec),
                                   c_reset_pc + 32'(4 * i));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_branch();
        test_jumps();
        test_stall_redirect();
        test_wrap();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mycpu_if_stage.md
Name: mycpu_if_stage

Overview:
- Instruction Fetch stage of the 5-stage MIPS pipeline.
- Owns the fetch PC register and drives the synchronous instruction SRAM (1-cycle read latency).
- Presents {PC, instruction, valid} combinationally to the ID stage.
- Applies ID's branch/jump redirect (branch delay slot honoured) and ID's stall (allowIN low).
- Flags misaligned fetch addresses and counts delivered instructions.

Parameters:
RESET_PC, 32'hBFC00000, address of the first fetch after reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_allowin  input  1  ID can consume the current instruction this cycle (0 = stall)
id_c1  input  2  redirect class from ID: 00 none, 01 PC-relative branch taken, 10 J/JAL region jump, 11 register jump
id_jmp_addr  input  32  from ID: byte offset (already <<2) when id_c1=01, absolute target otherwise
inst_sram_en  output  1  SRAM read enable
inst_sram_addr  output  32  SRAM byte address
inst_sram_rdata  input  32  SRAM read data, valid the cycle after the request
if_pc  output  32  PC of the instruction presented to ID
if_inst  output  32  instruction presented to ID (32'd0 when if_valid=0)
if_valid  output  1  if_pc/if_inst hold a real instruction
if_adel  output  1  if_pc[1:0] != 0 (address error on fetch); qualified by if_valid
perf_fetch_cnt  output  32  number of instructions accepted by ID since reset

Behaviour:
- Registers:
  - fetch_pc: address requested this cycle.
  - out_pc: address whose data is on inst_sram_rdata this cycle.
  - out_valid.
  - perf counter.
  - 2-state FSM: BOOT / RUN.
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, out_pc=0, out_valid=0, perf_fetch_cnt=0, FSM=BOOT.
  - While rst is high: inst_sram_en=0, if_valid=0, if_inst=0, if_pc=0.
- BOOT (one cycle after reset release):
  - inst_sram_en=1, addr=fetch_pc, if_valid=0.
  - Next state RUN, out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+4.
- RUN:
  - inst_sram_en=1, if_pc=out_pc, if_inst=inst_sram_rdata, if_valid=out_valid.
  - Advance (id_allowin=1): addr=fetch_pc; out_pc<=fetch_pc; out_valid<=1; perf_fetch_cnt += 1; fetch_pc<=next_pc.
  - Stall (id_allowin=0): addr=out_pc (re-read the held instruction so rdata is unchanged next cycle); out_pc, fetch_pc and perf counter hold.
- next_pc (when advancing):
  - id_c1=01: out_pc + 4 + id_jmp_addr (the branch is at out_pc; the delay slot is fetch_pc, already requested this cycle).
  - id_c1=10 or 11: id_jmp_addr.
  - 00: fetch_pc + 4.
  - All additions are modulo 2^32; wrap from 32'hFFFFFFFC to 0 is silent.
- Redirect under stall:
  - ID forces id_c1=00 while paused, so id_c1 is ignored when id_allowin=0.
  - A non-zero id_c1 with id_allowin=0 has no effect. The bench checks this.
- Delay slot: the instruction at branch_pc+4 is always delivered with if_valid=1 before the target.
- Misaligned target:
  - Fetch proceeds with the address as given (SRAM ignores addr[1:0]).
  - if_adel=1 while that PC is presented; no suppression in this block.
- Latency:
  - Reset release to first if_valid=1 is 2 cycles.
  - Redirect takes effect after exactly 2 instructions (branch, then delay slot).
- Reset mid-operation: synchronous reset overrides stall and redirect in the same cycle. All state returns to reset values.
- perf_fetch_cnt wraps 32'hFFFFFFFF -> 0.

Test Plan:
- Boot: assert rst 3 cycles, release with id_allowin=1, SRAM returning addr-based data -> if_valid=0 for 1 cycle after release, then if_pc=BFC00000, BFC00004, BFC00008 on consecutive cycles; perf_fetch_cnt=1,2,3 after each.
- Stall: in RUN at if_pc=BFC00010, hold id_allowin=0 for 3 cycles -> if_pc/if_inst stable at BFC00010 and its data, inst_sram_addr=BFC00010, perf_fetch_cnt frozen; release -> BFC00014 next.
- Branch: at if_pc=BFC00020, drive id_c1=01, id_jmp_addr=32'hFFFFFFF0 -> next if_pc=BFC00024 (delay slot), then BFC00014.
- Jumps: id_c1=10, jmp=BFC00100 at if_pc=BFC00030 -> BFC00034, then BFC00100. id_c1=11, jmp=BFC00202 -> delay slot, then if_pc=BFC00202 with if_adel=1.
- Stall + redirect: id_allowin=0 with id_c1=10, jmp=0 -> no redirect, sequence resumes at out_pc+4 after release.
- Reset mid-run: assert rst during a stall -> next cycle if_valid=0, perf_fetch_cnt=0; restart from BFC00000 after release.
